// File: rtl/demux_stream_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer: channel codes,
// default geometry and the channel-select helper.
package demux_stream_pkg;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 2;
  localparam int CNT_W_DEF = 16;

  function automatic logic is_ch(input logic sel, input logic ch);
    return (sel == ch);
  endfunction

endpackage

// File: rtl/demux_stream_chan_fifo.sv
// Per-channel FIFO with a registered head word and registered valid flag.
// A full FIFO refuses a push even when the same cycle pops (no pass-through).
module chan_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_ptr_inc_s;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             push_ok_s, pop_ok_s;

  assign full_o  = (count_q == CW'(DEPTH));
  assign valid_o = valid_q;
  assign head_o  = head_q;

  always_comb begin
    push_ok_s    = push_i & ~full_o;
    pop_ok_s     = pop_i & valid_q;
    rd_ptr_inc_s = rd_ptr_q + AW'(1);
    wr_ptr_d     = push_ok_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d     = pop_ok_s ? rd_ptr_inc_s : rd_ptr_q;

    if (push_ok_s && !pop_ok_s) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok_s && pop_ok_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
    valid_d = (count_d != CW'(0));

    // Head follows the next stored word on pop; a word pushed into an
    // otherwise-empty FIFO (or one being drained to empty) becomes the head.
    head_d = head_q;
    if (pop_ok_s) begin
      if (count_q > CW'(1)) begin
        head_d = mem_q[rd_ptr_inc_s];
      end else if (push_ok_s) begin
        head_d = push_data_i;
      end else begin
        head_d = head_q;
      end
    end else if (push_ok_s && (count_q == CW'(0))) begin
      head_d = push_data_i;
    end else begin
      head_d = head_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok_s && !rst_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/demux_stream.sv
// 1-to-2 stream demultiplexer: steers each accepted word into the FIFO of
// its selected channel and counts routed words per channel.
module demux_stream
  import demux_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic             selCh,
  input  logic [WIDTH-1:0] inData,
  output logic             outValid0,
  input  logic             outReady0,
  output logic [WIDTH-1:0] outCh0,
  output logic             outValid1,
  input  logic             outReady1,
  output logic [WIDTH-1:0] outCh1,
  output logic [CNT_W-1:0] routeCnt0,
  output logic [CNT_W-1:0] routeCnt1
);

  logic             full0_s, full1_s, sel_full_s;
  logic             accept_s, push0_s, push1_s;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    sel_full_s = is_ch(selCh, CH1) ? full1_s : full0_s;
    inReady    = ~rst & ~sel_full_s;
    accept_s   = inValid & inReady;
    push0_s    = accept_s & is_ch(selCh, CH0);
    push1_s    = accept_s & is_ch(selCh, CH1);
    cnt0_d     = push0_s ? (cnt0_q + CNT_W'(1)) : cnt0_q;
    cnt1_d     = push1_s ? (cnt1_q + CNT_W'(1)) : cnt1_q;
  end

  // Routed-word counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign routeCnt0 = cnt0_q;
  assign routeCnt1 = cnt1_q;

  chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push0_s),
    .push_data_i (inData),
    .pop_i       (outReady0),
    .full_o      (full0_s),
    .valid_o     (outValid0),
    .head_o      (outCh0)
  );

  chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push1_s),
    .push_data_i (inData),
    .pop_i       (outReady1),
    .full_o      (full1_s),
    .valid_o     (outValid1),
    .head_o      (outCh1)
  );

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: directed scenarios plus random traffic
// checked against a queue-based model of the two channel FIFOs.
module tb_demux_stream;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic        selCh = 1'b0;
  logic [31:0] inData = 32'd0;
  logic        outValid0, outValid1;
  logic        outReady0 = 1'b0;
  logic        outReady1 = 1'b0;
  logic [31:0] outCh0, outCh1;
  logic [15:0] routeCnt0, routeCnt1;

  int checks = 0;
  int errors = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [15:0] m_cnt0 = 16'd0;
  logic [15:0] m_cnt1 = 16'd0;
  logic        exp_rdy;
  logic        rdy_seen;

  demux_stream dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .selCh(selCh),
    .inData(inData), .outValid0(outValid0), .outReady0(outReady0), .outCh0(outCh0),
    .outValid1(outValid1), .outReady1(outReady1), .outCh1(outCh1),
    .routeCnt0(routeCnt0), .routeCnt1(routeCnt1)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, observe inReady before the edge, advance the model.
  task automatic step(input logic v, input logic s, input logic [31:0] d,
                      input logic r0, input logic r1);
    logic acc, p0, p1;
    inValid = v; selCh = s; inData = d; outReady0 = r0; outReady1 = r1;
    exp_rdy = !rst && ((s ? q1.size() : q0.size()) < DEPTH);
    acc = v && exp_rdy;
    p0  = !rst && r0 && (q0.size() != 0);
    p1  = !rst && r1 && (q1.size() != 0);
    #2;
    rdy_seen = inReady;
    @(posedge clk);
    if (rst) begin
      q0.delete(); q1.delete();
      m_cnt0 = 16'd0; m_cnt1 = 16'd0;
    end else begin
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (acc) begin
        if (s) begin q1.push_back(d); m_cnt1 = m_cnt1 + 16'd1; end
        else   begin q0.push_back(d); m_cnt0 = m_cnt0 + 16'd1; end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 32'd9, 1'b1, 1'b1);
      checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL reset_inready got %b exp 0", rdy_seen); end
    end
    checks++; if (outValid0 !== 1'b0) begin errors++; $display("FAIL reset_valid0 got %b exp 0", outValid0); end
    checks++; if (outValid1 !== 1'b0) begin errors++; $display("FAIL reset_valid1 got %b exp 0", outValid1); end
    checks++; if (outCh0 !== 32'd0) begin errors++; $display("FAIL reset_ch0 got %h exp 0", outCh0); end
    checks++; if (outCh1 !== 32'd0) begin errors++; $display("FAIL reset_ch1 got %h exp 0", outCh1); end
    checks++; if (routeCnt0 !== 16'd0) begin errors++; $display("FAIL reset_cnt0 got %h exp 0", routeCnt0); end
    checks++; if (routeCnt1 !== 16'd0) begin errors++; $display("FAIL reset_cnt1 got %h exp 0", routeCnt1); end
    rst = 1'b0;
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    checks++; if (rdy_seen !== 1'b1) begin errors++; $display("FAIL post_reset_inready got %b exp 1", rdy_seen); end
  endtask

  task automatic test_basic();
    step(1'b1, 1'b0, 32'd102, 1'b1, 1'b1);
    checks++; if (outValid0 !== 1'b1 || outCh0 !== 32'd102) begin errors++; $display("FAIL basic_ch0 got v=%b %0d exp v=1 102", outValid0, outCh0); end
    step(1'b1, 1'b1, 32'd15, 1'b1, 1'b1);
    checks++; if (outValid1 !== 1'b1 || outCh1 !== 32'd15) begin errors++; $display("FAIL basic_ch1 got v=%b %0d exp v=1 15", outValid1, outCh1); end
    checks++; if (outValid0 !== 1'b0) begin errors++; $display("FAIL basic_pop0 got %b exp 0", outValid0); end
    checks++; if (routeCnt0 !== 16'd1 || routeCnt1 !== 16'd1) begin errors++; $display("FAIL basic_cnt got %0d/%0d exp 1/1", routeCnt0, routeCnt1); end
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    checks++; if (outValid1 !== 1'b0) begin errors++; $display("FAIL basic_drain1 got %b exp 0", outValid1); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_heads [3];
    exp_heads[0] = 32'd53; exp_heads[1] = 32'd77; exp_heads[2] = 32'd99;
    step(1'b1, 1'b0, 32'd53, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'd77, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'd99, 1'b0, 1'b1);
    checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL bp_full_inready got %b exp 0", rdy_seen); end
    step(1'b1, 1'b1, 32'hAA, 1'b0, 1'b0);
    checks++; if (rdy_seen !== 1'b1 || outCh1 !== 32'hAA) begin errors++; $display("FAIL bp_other_ch got rdy=%b %h exp rdy=1 aa", rdy_seen, outCh1); end
    checks++; if (outCh0 !== exp_heads[0]) begin errors++; $display("FAIL bp_head0 got %0d exp %0d", outCh0, exp_heads[0]); end
    // Full with a same-cycle pop: 99 still refused, head advances to 77.
    step(1'b1, 1'b0, 32'd99, 1'b1, 1'b1);
    checks++; if (rdy_seen !== 1'b0 || outCh0 !== exp_heads[1]) begin errors++; $display("FAIL bp_no_passthru got rdy=%b %0d exp rdy=0 %0d", rdy_seen, outCh0, exp_heads[1]); end
    step(1'b1, 1'b0, 32'd99, 1'b1, 1'b1);
    checks++; if (rdy_seen !== 1'b1 || outCh0 !== exp_heads[2]) begin errors++; $display("FAIL bp_head2 got rdy=%b %0d exp rdy=1 %0d", rdy_seen, outCh0, exp_heads[2]); end
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    checks++; if (outValid0 !== 1'b0 || routeCnt0 !== m_cnt0) begin errors++; $display("FAIL bp_drain got v=%b cnt=%0d exp v=0 cnt=%0d", outValid0, routeCnt0, m_cnt0); end
  endtask

  task automatic test_same_cycle();
    step(1'b1, 1'b0, 32'd11, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd5, 1'b1, 1'b0);
    checks++; if (outValid0 !== 1'b1 || outCh0 !== 32'd5) begin errors++; $display("FAIL same_head got v=%b %0d exp v=1 5", outValid0, outCh0); end
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checks++; if (outValid0 !== 1'b0) begin errors++; $display("FAIL same_occupancy got %b exp 0", outValid0); end
  endtask

  task automatic test_counter_wrap();
    rst = 1'b1;
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 16'hFFFE; i++) step(1'b1, 1'b1, $urandom, 1'b0, 1'b1);
    checks++; if (routeCnt1 !== 16'hFFFE || m_cnt1 !== 16'hFFFE) begin errors++; $display("FAIL wrap_preload got %h exp fffe", routeCnt1); end
    step(1'b1, 1'b1, 32'd1, 1'b0, 1'b1);
    checks++; if (routeCnt1 !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff got %h exp ffff", routeCnt1); end
    step(1'b1, 1'b1, 32'd2, 1'b0, 1'b1);
    checks++; if (routeCnt1 !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h exp 0000", routeCnt1); end
    checks++; if (routeCnt0 !== 16'h0000) begin errors++; $display("FAIL wrap_cnt0 got %h exp 0000", routeCnt0); end
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 32'd31, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'd32, 1'b0, 1'b0);
    checks++; if (outValid1 !== 1'b1 || outCh1 !== 32'd31) begin errors++; $display("FAIL mid_preload got v=%b %0d exp v=1 31", outValid1, outCh1); end
    rst = 1'b1;
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    rst = 1'b0;
    checks++; if (outValid1 !== 1'b0) begin errors++; $display("FAIL mid_flush got %b exp 0", outValid1); end
    step(1'b1, 1'b1, 32'd7, 1'b0, 1'b0);
    checks++; if (outValid1 !== 1'b1 || outCh1 !== 32'd7) begin errors++; $display("FAIL mid_newhead got v=%b %0d exp v=1 7", outValid1, outCh1); end
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    checks++; if (outValid1 !== 1'b0) begin errors++; $display("FAIL mid_no_stale got %b exp 0", outValid1); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom,
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      checks++; if (rdy_seen !== exp_rdy) begin errors++; $display("FAIL rnd_inready cyc %0d got %b exp %b", i, rdy_seen, exp_rdy); end
      checks++; if (outValid0 !== (q0.size() != 0) || outValid1 !== (q1.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b%b exp %b%b", i, outValid0, outValid1, q0.size() != 0, q1.size() != 0); end
      if (q0.size() != 0) begin
        checks++; if (outCh0 !== q0[0]) begin errors++; $display("FAIL rnd_ch0 cyc %0d got %h exp %h", i, outCh0, q0[0]); end
      end
      if (q1.size() != 0) begin
        checks++; if (outCh1 !== q1[0]) begin errors++; $display("FAIL rnd_ch1 cyc %0d got %h exp %h", i, outCh1, q1[0]); end
      end
      checks++; if (routeCnt0 !== m_cnt0 || routeCnt1 !== m_cnt1) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d/%0d exp %0d/%0d", i, routeCnt0, routeCnt1, m_cnt0, m_cnt1); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_same_cycle();
    test_reset_mid();
    test_random();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
